any1_lane_target: RTL and testbench

- Bus-target end of the ANY-1 load/store byte-lane protocol.
- The core issues classic-cycle requests on a 256-bit data bus with a 32-bit byte-lane select. The select is a width mask of 2, 4, 8, 16 or 32 bytes, shifted left by adr[4:0].
- This block checks the select against the address, performs byte-lane-masked writes into a local line RAM, and returns lane-masked read data with an ack/err handshake.
- It sits on the core's data bus as a scratchpad target and doubles as the reference responder for load/store verification.

---
 rtl/any1_pkg.sv | 41 ++++
 rtl/any1_lane_target_if.sv | 20 ++
 rtl/any1_lane_ram.sv | 44 ++++
 rtl/any1_lane_target.sv | 101 ++++++++++
 tb/tb_any1_lane_target.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/any1_pkg.sv
// Shared definitions for the ANY-1 byte-lane bus target: lane-width masks,
// target FSM states and select/lane helper functions.
package any1_pkg;

   localparam logic [31:0] SEL_B2  = 32'h0000_0003;
   localparam logic [31:0] SEL_B4  = 32'h0000_000F;
   localparam logic [31:0] SEL_B8  = 32'h0000_00FF;
   localparam logic [31:0] SEL_B16 = 32'h0000_FFFF;
   localparam logic [31:0] SEL_B32 = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {TS_IDLE, TS_RD_WAIT, TS_HOLD} target_state_e;

   // A select is legal only as a naturally aligned width mask that stays inside bit 31.
   function automatic logic sel_legal(input logic [31:0] sel, input logic [4:0] adr5);
      logic [31:0] w [5];
      logic [4:0]  align;
      logic [63:0] shifted;
      logic        ok;
      w[0] = SEL_B2;
      w[1] = SEL_B4;
      w[2] = SEL_B8;
      w[3] = SEL_B16;
      w[4] = SEL_B32;
      ok   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         align   = 5'((6'd2 << i) - 6'd1);
         shifted = {32'd0, w[i]} << adr5;
         if (((adr5 & align) == 5'd0) && (shifted[63:32] == 32'd0) && (shifted[31:0] == sel))
            ok = 1'b1;
      end
      return ok;
   endfunction

   function automatic logic [255:0] lane_mask(input logic [31:0] sel);
      logic [255:0] m;
      for (int n = 0; n < 32; n++)
         m[8*n +: 8] = {8{sel[n]}};
      return m;
   endfunction

endpackage

// File: rtl/any1_lane_target_if.sv
// Classic-cycle byte-lane bus between the ANY-1 core (master) and a target (slave).
interface any1_lane_target_if;
   // A request is valid while cyc_i & stb_i; the target answers with exactly one
   // of ack_o/err_o, holds it (and dat_o) while stb_i stays high, and drops it
   // on the edge after stb_i falls.
   logic         cyc_i;
   logic         stb_i;
   logic         we_i;
   logic [31:0]  sel_i;
   logic [31:0]  adr_i;
   logic [255:0] dat_i;
   logic         ack_o;
   logic         err_o;
   logic [255:0] dat_o;

   modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                   input  ack_o, err_o, dat_o);
   modport slave  (input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                   output ack_o, err_o, dat_o);
endinterface

// File: rtl/any1_lane_ram.sv
// DEPTH x 256-bit line RAM with per-byte write enables and an RD_LAT-stage
// registered read pipeline. Contents survive reset; only the pipeline clears.
module any1_lane_ram #(
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   be,
   input  logic [255:0]  wdata,
   input  logic          rd_en,
   output logic [255:0]  rd_data,
   output logic          rd_valid
);

   logic [255:0]      mem  [DEPTH];
   logic [255:0]      pipe [RD_LAT];
   logic [RD_LAT-1:0] vld;

   always_ff @(posedge clk) begin
      for (int n = 0; n < 32; n++)
         if (be[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         vld[0] <= rd_en;
         if (rd_en) pipe[0] <= mem[idx];
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i]  <= vld[i-1];
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign rd_data  = pipe[RD_LAT-1];
   assign rd_valid = vld[RD_LAT-1];

endmodule

// File: rtl/any1_lane_target.sv
// ANY-1 byte-lane bus target: decodes the window, validates the select,
// writes lanes into the line RAM and returns lane-masked read data.
module any1_lane_target
   import any1_pkg::*;
#(
   parameter int          DEPTH  = 64,
   parameter int          RD_LAT = 2,
   parameter logic [31:0] BASE   = 32'hFFD00000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   any1_lane_target_if.slave bus,
   output target_state_e state
);

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [1:0] LAST = 2'(RD_LAT - 1);

   logic          hit;
   logic          legal;
   logic          wr_en;
   logic          rd_en;
   logic [255:0]  rd_data;
   logic          rd_valid;
   logic [31:0]   sel_q;
   logic [1:0]    cnt;
   logic          ack_q;
   logic          err_q;
   logic [255:0]  dat_q;

   assign hit   = bus.cyc_i & bus.stb_i & (bus.adr_i[31:5+AW] == BASE[31:5+AW]);
   assign legal = sel_legal(bus.sel_i, bus.adr_i[4:0]);
   assign wr_en = (state == TS_IDLE) & hit & legal & bus.we_i;
   assign rd_en = (state == TS_IDLE) & hit & legal & ~bus.we_i;

   any1_lane_ram #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_ram (
      .clk      (clk_i),
      .rst      (rst_i),
      .idx      (bus.adr_i[5+AW-1:5]),
      .be       (wr_en ? bus.sel_i : 32'd0),
      .wdata    (bus.dat_i),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= TS_IDLE;
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
         sel_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            TS_IDLE: begin
               if (hit) begin
                  if (!legal) begin
                     err_q <= 1'b1;
                     state <= TS_HOLD;
                  end else if (bus.we_i) begin
                     ack_q <= 1'b1;
                     state <= TS_HOLD;
                  end else begin
                     sel_q <= bus.sel_i;
                     cnt   <= '0;
                     state <= TS_RD_WAIT;
                  end
               end
            end
            TS_RD_WAIT: begin
               // The counter, not rd_valid alone, decides completion so that a
               // stale read left in the pipeline by an abort is never returned.
               if (!(bus.cyc_i && bus.stb_i)) begin
                  state <= TS_IDLE;
               end else if (rd_valid && (cnt == LAST)) begin
                  dat_q <= rd_data & lane_mask(sel_q);
                  ack_q <= 1'b1;
                  state <= TS_HOLD;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            TS_HOLD: begin
               if (!bus.stb_i) begin
                  ack_q <= 1'b0;
                  err_q <= 1'b0;
                  state <= TS_IDLE;
               end
            end
            default: state <= TS_IDLE;
         endcase
      end
   end

   assign bus.ack_o = ack_q;
   assign bus.err_o = err_q;
   assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_any1_lane_target.sv
// Self-checking bench for any1_lane_target: directed protocol steps followed by
// randomized transactions against a line-array reference model.
module tb_any1_lane_target;
   import any1_pkg::*;

   localparam int          DEPTH  = 64;
   localparam int          RD_LAT = 2;
   localparam logic [31:0] BASE   = 32'hFFD00000;
   localparam int          NLINES = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   target_state_e state;

   any1_lane_target_if bus();

   any1_lane_target #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .BASE(BASE)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus),
      .state (state)
   );

   always #5 clk_i = ~clk_i;

   int           n_vec = 0;
   int           n_err = 0;
   logic [255:0] ref_mem [NLINES];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic model_legal(input logic [31:0] sel, input int adr5);
      logic [63:0] m;
      for (int b = 2; b <= 32; b = b * 2) begin
         m = ((64'd1 << b) - 64'd1) << adr5;
         if ((adr5 % b) == 0 && m[63:32] == 32'd0 && m[31:0] == sel) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [255:0] model_lanes(input logic [31:0] sel);
      logic [255:0] m;
      m = '0;
      for (int n = 0; n < 32; n++)
         if (sel[n]) m = m | (256'hFF << (8 * n));
      return m;
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // ---------------- driver ----------------
   task automatic idle_bus();
      bus.cyc_i = 1'b0;
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.sel_i = '0;
      bus.adr_i = '0;
      bus.dat_i = '0;
   endtask

   // resp: 0 none, 1 ack, 2 err, 3 both; lat counts edges starting with the acceptance edge
   task automatic do_req(input logic we, input logic [31:0] sel, input logic [31:0] adr,
                         input logic [255:0] wd, output int resp, output int lat,
                         output logic [255:0] rd);
      @(negedge clk_i);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.sel_i = sel;
      bus.adr_i = adr;
      bus.dat_i = wd;
      resp = 0;
      lat  = 0;
      for (int i = 0; i < 12 && resp == 0; i++) begin
         @(posedge clk_i);
         #1;
         lat++;
         if (bus.ack_o && bus.err_o) resp = 3;
         else if (bus.ack_o)         resp = 1;
         else if (bus.err_o)         resp = 2;
      end
      rd = bus.dat_o;
   endtask

   task automatic release_bus(input string tag);
      idle_bus();
      @(posedge clk_i);
      #1;
      check({tag, "_rel_ack"}, bus.ack_o, 1'b0);
      check({tag, "_rel_err"}, bus.err_o, 1'b0);
   endtask

   // One complete transaction checked against the model, then released.
   task automatic txn(input string tag, input logic we, input logic [31:0] sel,
                      input logic [31:0] adr, input logic [255:0] wd);
      int           resp, lat, line;
      logic         legal;
      logic [255:0] rd, exp_rd, mask;
      line   = int'(adr[7:5]);
      legal  = model_legal(sel, int'(adr[4:0]));
      mask   = model_lanes(sel);
      exp_rd = ref_mem[line] & mask;
      do_req(we, sel, adr, wd, resp, lat, rd);
      check({tag, "_resp"}, resp, legal ? 1 : 2);
      check({tag, "_lat"}, lat, (legal && !we) ? RD_LAT + 1 : 1);
      if (legal && !we) check({tag, "_data"}, rd, exp_rd);
      if (legal && we) ref_mem[line] = (ref_mem[line] & ~mask) | (wd & mask);
      release_bus(tag);
   endtask

   initial begin
      int           resp, lat, cnt, k, w, off, line, adr5;
      logic [255:0] rd, hold_dat, wd;
      logic [31:0]  sel;
      logic         we;

      idle_bus();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ack", bus.ack_o, 1'b0);
      check("rst_err", bus.err_o, 1'b0);
      check("rst_dat", bus.dat_o, 256'd0);
      check("rst_state", state, TS_IDLE);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Initialise the lines the bench uses; line 0 holds 0x11 in every byte.
      for (int i = 0; i < NLINES; i++) ref_mem[i] = '0;
      txn("init0", 1'b1, SEL_B32, BASE, {32{8'h11}});
      for (int i = 1; i < NLINES; i++) txn("init", 1'b1, SEL_B32, BASE + 32 * i, rand_line());

      // 4-byte lane write, then full-line read of the same line
      wd = rand_line();
      wd[63:32] = 32'hDEADBEEF;
      txn("wr4", 1'b1, 32'h0000_00F0, BASE + 32'h24, wd);
      do_req(1'b0, SEL_B32, BASE + 32'h20, '0, resp, lat, rd);
      check("rd32_resp", resp, 1);
      check("rd32_bytes4_7", rd[63:32], 32'hDEADBEEF);
      check("rd32_line", rd, ref_mem[1]);
      release_bus("rd32");

      // Lane-masked read of line 0
      do_req(1'b0, 32'h0000_FF00, BASE + 32'h08, '0, resp, lat, rd);
      check("rd8_resp", resp, 1);
      check("rd8_lat", lat, RD_LAT + 1);
      check("rd8_data", rd, {64'h1111_1111_1111_1111, 64'd0} << 0 << 0 == 0 ? '0 : (256'h1111_1111_1111_1111 << 64));
      release_bus("rd8");

      // Illegal selects, then confirm line 0 untouched
      txn("ill_sel6", 1'b1, 32'h0000_0006, BASE + 32'h01, rand_line());
      txn("ill_sel0", 1'b1, 32'h0000_0000, BASE, rand_line());
      txn("ill_mis16", 1'b0, 32'h0000_FFFF, BASE + 32'h08, '0);
      txn("ill_chk", 1'b0, SEL_B32, BASE, '0);
      check("ill_line0", ref_mem[0], {32{8'h11}});

      // Hold ack for 5 cycles, release, then immediate re-strobe
      do_req(1'b0, SEL_B32, BASE + 32'h20, '0, resp, lat, rd);
      check("hold_resp", resp, 1);
      hold_dat = rd;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         check("hold_ack", bus.ack_o, 1'b1);
         check("hold_dat", bus.dat_o, hold_dat);
      end
      release_bus("hold");
      txn("restrobe", 1'b1, SEL_B16 << 16, BASE + 32'h50, rand_line());

      // Abort a read by dropping cyc_i in RD_WAIT
      @(negedge clk_i);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = 1'b0;
      bus.sel_i = SEL_B32;
      bus.adr_i = BASE + 32'h40;
      @(posedge clk_i);
      #1;
      check("abort_rdwait", state, TS_RD_WAIT);
      bus.cyc_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i);
         #1;
         if (bus.ack_o || bus.err_o) cnt++;
      end
      check("abort_noresp", cnt, 0);
      check("abort_idle", state, TS_IDLE);
      release_bus("abort");

      // Reset while holding an ack; RAM must retain the write
      wd = rand_line();
      do_req(1'b1, SEL_B32, BASE + 32'h40, wd, resp, lat, rd);
      check("rsthold_resp", resp, 1);
      ref_mem[2] = wd;
      #2;
      rst_i = 1'b1;
      #1;
      check("rsthold_ack", bus.ack_o, 1'b0);
      check("rsthold_state", state, TS_IDLE);
      idle_bus();
      @(negedge clk_i);
      rst_i = 1'b0;
      txn("rst_keep", 1'b0, SEL_B32, BASE + 32'h40, '0);

      // Out-of-window access stays silent
      @(negedge clk_i);
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = 1'b0;
      bus.sel_i = SEL_B32;
      bus.adr_i = BASE - 32;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_i);
         #1;
         if (bus.ack_o || bus.err_o) cnt++;
      end
      check("oow_silent", cnt, 0);
      release_bus("oow");

      // Randomized transactions
      for (int t = 0; t < 60; t++) begin
         line = $urandom_range(0, NLINES - 1);
         we   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            k    = $urandom_range(0, 4);
            w    = 2 << k;
            off  = $urandom_range(0, 32 / w - 1) * w;
            sel  = 32'(((64'd1 << w) - 64'd1) << off);
            adr5 = off;
         end else begin
            sel  = $urandom;
            adr5 = $urandom_range(0, 31);
         end
         txn("rand", we, sel, BASE + 32'(32 * line + adr5), rand_line());
      end
      for (int i = 0; i < NLINES; i++) txn("final", 1'b0, SEL_B32, BASE + 32 * i, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
